// File: rtl/hpm_csr_pkg.sv
// Shared constants for the hardware performance-monitor CSR block.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package hpm_csr_pkg;

    // Machine-mode counter addresses (low / high halves)
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] ADDR_MHPMCOUNTER3H = 12'hB83;

    // Event selectors and inhibit mask
    localparam logic [11:0] ADDR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

    // Read-only user aliases
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [11:0] ADDR_HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] ADDR_HPMCOUNTER3H  = 12'hC83;

    // CSR operation carried in funct3[1:0]
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // mcountinhibit bit positions
    localparam int INH_CY       = 0;
    localparam int INH_IR       = 2;
    localparam int INH_HPM_BASE = 3;

    // Address offset of counter c from the cycle counter's address.
    // Slot +1 is the unimplemented time counter, so instret sits at +2.
    function automatic logic [11:0] cnt_addr_off(input int c);
        if (c == 0) return 12'd0;
        return 12'(c + 1);
    endfunction

endpackage

// File: rtl/hpm_counter.sv
// One wide event counter with split low/high write ports and a wrap pulse.
// Latency: writes and increments visible one cycle after the edge; ovf is a registered 1-cycle pulse.
// Backpressure: none; a write always overrides an increment in the same cycle.
module hpm_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_en,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // Next count: a write to either half wins over the increment
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (wr_lo) begin
            cnt_d = {cnt_q[CNT_WIDTH-1:32], wdata};
        end else if (wr_hi) begin
            cnt_d = {wdata[CNT_WIDTH-33:0], cnt_q[31:0]};
        end else if (inc_en) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            ovf_d = &cnt_q;
        end
    end

    // Counter and overflow pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/hpm_csr.sv
// Performance-monitor CSR file: cycle, instret and NUM_HPM event counters with selectors and inhibit.
// Latency: reads and illegal are combinational; writes and increments take effect at the next edge.
// Backpressure: none; every access completes in the cycle it is presented.
module hpm_csr
    import hpm_csr_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_retire,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [11:0]           csr_addr,
    input  logic                  csr_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  illegal,
    output logic [NUM_HPM+1:0]    ovf
);

    localparam int NCNT = NUM_HPM + 2;
    // Only cycle, instret and the implemented hpm counters can be inhibited
    localparam logic [31:0] INH_MASK =
        (32'd1 << INH_CY) | (32'd1 << INH_IR) |
        32'(((64'd1 << NUM_HPM) - 64'd1) << INH_HPM_BASE);

    logic [CNT_WIDTH-1:0] cnt_val [NCNT];
    logic [NCNT-1:0]      inc_en, wr_lo, wr_hi, sel_lo, sel_hi;
    logic [NUM_HPM-1:0]   sel_ev;
    logic                 sel_inh, hit, writable, we;
    logic [31:0]          wval;
    csr_op_e              op;
    logic [4:0]           mhpmevent_q [NUM_HPM];
    logic [4:0]           mhpmevent_d [NUM_HPM];
    logic [31:0]          mcountinhibit_q, mcountinhibit_d;
    logic                 unused_funct3;

    assign unused_funct3 = funct3[2];

    // Address decode and read mux; aliases hit but are not writable
    always_comb begin
        hit      = 1'b0;
        writable = 1'b0;
        rdata    = '0;
        sel_lo   = '0;
        sel_hi   = '0;
        sel_ev   = '0;
        sel_inh  = 1'b0;
        for (int c = 0; c < NCNT; c++) begin
            if (csr_addr == ADDR_MCYCLE + cnt_addr_off(c)) begin
                hit       = 1'b1;
                writable  = 1'b1;
                sel_lo[c] = 1'b1;
                rdata     = cnt_val[c][31:0];
            end
            if (csr_addr == ADDR_MCYCLEH + cnt_addr_off(c)) begin
                hit       = 1'b1;
                writable  = 1'b1;
                sel_hi[c] = 1'b1;
                rdata     = 32'(cnt_val[c][CNT_WIDTH-1:32]);
            end
            if (csr_addr == ADDR_CYCLE + cnt_addr_off(c)) begin
                hit   = 1'b1;
                rdata = cnt_val[c][31:0];
            end
            if (csr_addr == ADDR_CYCLEH + cnt_addr_off(c)) begin
                hit   = 1'b1;
                rdata = 32'(cnt_val[c][CNT_WIDTH-1:32]);
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_addr == ADDR_MHPMEVENT3 + 12'(i)) begin
                hit       = 1'b1;
                writable  = 1'b1;
                sel_ev[i] = 1'b1;
                rdata     = {27'd0, mhpmevent_q[i]};
            end
        end
        if (csr_addr == ADDR_MCOUNTINHIBIT) begin
            hit      = 1'b1;
            writable = 1'b1;
            sel_inh  = 1'b1;
            rdata    = mcountinhibit_q;
        end
        illegal = !hit || (csr_write && !writable);
    end

    // Write operand, write strobes and next state of selector/inhibit registers
    always_comb begin
        op = csr_op_e'(funct3[1:0]);
        we = csr_write && (op != CSR_OP_NONE) && writable;
        case (op)
            CSR_OP_RW: wval = wdata;
            CSR_OP_RS: wval = rdata | wdata;
            CSR_OP_RC: wval = rdata & ~wdata;
            default:   wval = rdata;
        endcase
        wr_lo = sel_lo & {NCNT{we}};
        wr_hi = sel_hi & {NCNT{we}};
        mhpmevent_d = mhpmevent_q;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (we && sel_ev[i]) mhpmevent_d[i] = wval[4:0];
        end
        mcountinhibit_d = mcountinhibit_q;
        if (we && sel_inh) mcountinhibit_d = wval & INH_MASK;
    end

    // Per-counter increment enables; out-of-range selectors match no event
    always_comb begin
        inc_en    = '0;
        inc_en[0] = !mcountinhibit_q[INH_CY];
        inc_en[1] = !mcountinhibit_q[INH_IR] && inst_retire;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (mhpmevent_q[i] == 5'(k + 1)) inc_en[2+i] = event_i[k];
            end
            inc_en[2+i] = inc_en[2+i] && !mcountinhibit_q[INH_HPM_BASE+i];
        end
    end

    // Event selector and inhibit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HPM; i++) mhpmevent_q[i] <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mhpmevent_q     <= mhpmevent_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end

    for (genvar c = 0; c < NCNT; c++) begin : g_cnt
        hpm_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_en (inc_en[c]),
            .wr_lo  (wr_lo[c]),
            .wr_hi  (wr_hi[c]),
            .wdata  (wval),
            .cnt    (cnt_val[c]),
            .ovf    (ovf[c])
        );
    end

endmodule

// File: tb/tb_hpm_csr.sv
// Randomized and directed check of hpm_csr against a behavioural counter model.
// Latency: model updates once per rising edge; outputs sampled 1 time unit after the falling edge.
// Backpressure: n/a.
module tb_hpm_csr;

    localparam int NUM_HPM    = 4;
    localparam int CNT_WIDTH  = 64;
    localparam int NUM_EVENTS = 8;
    localparam int NCNT       = NUM_HPM + 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  inst_retire;
    logic [NUM_EVENTS-1:0] event_i;
    logic [11:0]           csr_addr;
    logic                  csr_write;
    logic [2:0]            funct3;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  illegal;
    logic [NUM_HPM+1:0]    ovf;

    always #5 clk = ~clk;

    hpm_csr #(
        .NUM_HPM    (NUM_HPM),
        .CNT_WIDTH  (CNT_WIDTH),
        .NUM_EVENTS (NUM_EVENTS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_retire (inst_retire),
        .event_i     (event_i),
        .csr_addr    (csr_addr),
        .csr_write   (csr_write),
        .funct3      (funct3),
        .wdata       (wdata),
        .rdata       (rdata),
        .illegal     (illegal),
        .ovf         (ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0]     m_cnt [NCNT];
    logic [NCNT-1:0] m_ovf;
    logic [4:0]      m_ev  [NUM_HPM];
    logic [31:0]     m_inh;

    typedef struct packed {
        logic       mapped;
        logic       ro;
        logic [1:0] kind;   // 1 counter, 2 event selector, 3 inhibit
        logic [4:0] idx;
        logic       hi;
    } dec_t;

    task automatic m_reset();
        for (int c = 0; c < NCNT; c++) m_cnt[c] = '0;
        for (int i = 0; i < NUM_HPM; i++) m_ev[i] = '0;
        m_ovf = '0;
        m_inh = '0;
    endtask

    function automatic dec_t m_decode(input logic [11:0] a);
        dec_t d;
        int   n;
        d = '0;
        n = int'(a[4:0]);
        if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
            if (n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM)) begin
                d.mapped = 1'b1;
                d.kind   = 2'd1;
                d.idx    = (n == 0) ? 5'd0 : 5'(n - 1);
                d.hi     = a[7];
                d.ro     = (a[11:8] == 4'hC);
            end
        end else if (a == 12'h320) begin
            d.mapped = 1'b1;
            d.kind   = 2'd3;
        end else if (int'(a) >= 'h323 && int'(a) < 'h323 + NUM_HPM) begin
            d.mapped = 1'b1;
            d.kind   = 2'd2;
            d.idx    = 5'(int'(a) - 'h323);
        end
        return d;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [11:0] a);
        dec_t d;
        d = m_decode(a);
        case (d.kind)
            2'd1:    return d.hi ? m_cnt[d.idx][63:32] : m_cnt[d.idx][31:0];
            2'd2:    return {27'd0, m_ev[d.idx]};
            2'd3:    return m_inh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_illegal();
        dec_t d;
        d = m_decode(csr_addr);
        return !d.mapped || (csr_write && d.ro);
    endfunction

    // Advance the model by one rising edge using the inputs currently applied
    task automatic m_step();
        dec_t        d;
        logic [31:0] old, nv, mask;
        logic        we;
        logic        inc [NCNT];
        int          e;
        d    = m_decode(csr_addr);
        old  = m_rdata(csr_addr);
        we   = csr_write && (funct3[1:0] != 2'b00) && d.mapped && !d.ro;
        mask = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
        case (funct3[1:0])
            2'b01:   nv = wdata;
            2'b10:   nv = old | wdata;
            2'b11:   nv = old & ~wdata;
            default: nv = old;
        endcase
        inc[0] = !m_inh[0];
        inc[1] = !m_inh[2] && inst_retire;
        for (int i = 0; i < NUM_HPM; i++) begin
            e = int'(m_ev[i]);
            inc[2+i] = 1'b0;
            if (e >= 1 && e <= NUM_EVENTS && !m_inh[3+i]) inc[2+i] = event_i[e-1];
        end
        m_ovf = '0;
        for (int c = 0; c < NCNT; c++) begin
            if (we && d.kind == 2'd1 && int'(d.idx) == c) begin
                if (d.hi) m_cnt[c][63:32] = nv;
                else      m_cnt[c][31:0]  = nv;
            end else if (inc[c]) begin
                if (m_cnt[c] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[c] = 1'b1;
                m_cnt[c] = m_cnt[c] + 64'd1;
            end
        end
        if (we && d.kind == 2'd2) m_ev[d.idx] = nv[4:0];
        if (we && d.kind == 2'd3) m_inh = nv & mask;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [11:0] a, input logic w, input logic [2:0] f,
                         input logic [31:0] d, input logic ir, input logic [NUM_EVENTS-1:0] ev);
        csr_addr    = a;
        csr_write   = w;
        funct3      = f;
        wdata       = d;
        inst_retire = ir;
        event_i     = ev;
    endtask

    // Check combinational outputs against the model, then take one clock edge
    task automatic cycle(input string tag);
        #1;
        check({tag, ":rdata"},   rdata,           m_rdata(csr_addr));
        check({tag, ":illegal"}, 32'(illegal),    32'(m_illegal()));
        check({tag, ":ovf"},     32'(ovf),        32'(m_ovf));
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    logic [31:0] mv;
    logic [31:0] rnd_d;
    logic [11:0] rnd_a;
    logic [7:0]  ir_pat;

    initial begin
        rst_n = 1'b0;
        drive(12'hC00, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        m_reset();
        @(negedge clk);
        #1;
        check("rst_cycle", rdata, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // 10 cycles, retire on 4 of them
        ir_pat = 8'b0101_0101;
        for (int k = 0; k < 10; k++) begin
            drive(12'hC00, 1'b0, 3'b000, 32'd0, (k < 8) ? ir_pat[k] : 1'b0, '0);
            cycle("cnt10");
        end
        drive(12'hC00, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("cycle_is_10", rdata, 32'd10);
        cycle("rd_c00");
        drive(12'hC02, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("instret_is_4", rdata, 32'd4);
        cycle("rd_c02");

        // cycle counter wrap
        drive(12'hB00, 1'b1, 3'b001, 32'hFFFF_FFFF, 1'b0, '0);
        cycle("wr_b00");
        drive(12'hB80, 1'b1, 3'b001, 32'hFFFF_FFFF, 1'b0, '0);
        cycle("wr_b80");
        drive(12'hC00, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("all_ones_lo", rdata, 32'hFFFF_FFFF);
        check("no_ovf_on_write", 32'(ovf[0]), 32'd0);
        cycle("pre_wrap");
        drive(12'hC80, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("wrap_hi_zero", rdata, 32'd0);
        check("ovf0_pulse", 32'(ovf[0]), 32'd1);
        cycle("wrap");
        drive(12'hC00, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("ovf0_one_cycle", 32'(ovf[0]), 32'd0);
        cycle("post_wrap");

        // event counting on hpm3
        drive(12'h323, 1'b1, 3'b001, 32'd3, 1'b0, '0);
        cycle("wr_ev3");
        for (int k = 0; k < 5; k++) begin
            drive(12'h323, 1'b0, 3'b000, 32'd0, 1'b0, 8'b0000_0100);
            cycle("ev_on");
        end
        for (int k = 0; k < 3; k++) begin
            drive(12'h323, 1'b0, 3'b000, 32'd0, 1'b0, 8'b0000_0001);
            cycle("ev_other");
        end
        drive(12'hB03, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("hpm3_is_5", rdata, 32'd5);
        cycle("rd_b03");

        // inhibit instret via RS, release via RC
        drive(12'h320, 1'b1, 3'b010, 32'h4, 1'b1, '0);
        cycle("inh_set");
        mv = m_cnt[1][31:0];
        for (int k = 0; k < 3; k++) begin
            drive(12'hC02, 1'b0, 3'b000, 32'd0, 1'b1, '0);
            #1 check("instret_held", rdata, mv);
            cycle("inh_hold");
        end
        drive(12'h320, 1'b1, 3'b011, 32'h4, 1'b1, '0);
        cycle("inh_clr");
        drive(12'hC02, 1'b0, 3'b000, 32'd0, 1'b1, '0);
        #1 check("instret_still", rdata, mv);
        cycle("inh_rel0");
        drive(12'hC02, 1'b0, 3'b000, 32'd0, 1'b1, '0);
        #1 check("instret_resumed", rdata, mv + 32'd1);
        cycle("inh_rel1");

        // illegal accesses
        drive(12'hC00, 1'b1, 3'b001, 32'h1234, 1'b0, '0);
        #1 check("wr_alias_illegal", 32'(illegal), 32'd1);
        cycle("wr_c00");
        drive(12'h7C0, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("unmapped_rdata", rdata, 32'd0);
        check("unmapped_illegal", 32'(illegal), 32'd1);
        cycle("rd_7c0");

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 9))
                0:       rnd_a = 12'hB00 | 12'($urandom_range(0, 7));
                1:       rnd_a = 12'hB80 | 12'($urandom_range(0, 7));
                2:       rnd_a = 12'hC00 | 12'($urandom_range(0, 7));
                3:       rnd_a = 12'hC80 | 12'($urandom_range(0, 7));
                4, 5:    rnd_a = 12'h320 + 12'($urandom_range(0, 7));
                6:       rnd_a = 12'($urandom);
                default: rnd_a = 12'hB03 + 12'($urandom_range(0, NUM_HPM - 1));
            endcase
            case ($urandom_range(0, 7))
                0, 1:    rnd_d = 32'hFFFF_FFFF;
                2:       rnd_d = 32'($urandom_range(0, 40));
                default: rnd_d = $urandom;
            endcase
            drive(rnd_a, 1'($urandom_range(0, 1)), 3'($urandom), rnd_d,
                  1'($urandom_range(0, 1)), NUM_EVENTS'($urandom));
            cycle("rnd");
        end

        // asynchronous reset between edges
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drive(12'hB00, 1'b0, 3'b000, 32'd0, 1'b0, '0);
        #1 check("async_rst_cycle", rdata, 32'd0);
        csr_addr = 12'hB02;
        #1 check("async_rst_instret", rdata, 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(12'h320 + 12'($urandom_range(0, 7)), 1'b0, 3'b000, 32'd0,
                  1'($urandom_range(0, 1)), NUM_EVENTS'($urandom));
            cycle("post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
